// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: ALU operator codes, aluop encodings and R-type funct codes.
// Imported by the ID/EX stage and its ALU-control decoder.
package mips_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] ALU_AND = 4'b0000;
  localparam logic [OPW-1:0] ALU_OR  = 4'b0001;
  localparam logic [OPW-1:0] ALU_ADD = 4'b0010;
  localparam logic [OPW-1:0] ALU_SUB = 4'b0110;
  localparam logic [OPW-1:0] ALU_SLT = 4'b0111;
  localparam logic [OPW-1:0] ALU_NOR = 4'b1100;
  localparam logic [OPW-1:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU-control decoder: aluop/funct -> 4-bit ALU operator.
// funct_ok is low only for an R-type with an unsupported funct (operator then ALU_NOP).
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0]     aluop,
  input  logic [5:0]     funct,
  output logic [OPW-1:0] operador,
  output logic           funct_ok
);

  always_comb begin
    operador = ALU_NOP;
    funct_ok = 1'b1;
    case (aluop_e'(aluop))
      ALUOP_ADD: operador = ALU_ADD;
      ALUOP_SUB: operador = ALU_SUB;
      ALUOP_OR:  operador = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: operador = ALU_ADD;
          FUNCT_SUB: operador = ALU_SUB;
          FUNCT_AND: operador = ALU_AND;
          FUNCT_OR:  operador = ALU_OR;
          FUNCT_SLT: operador = ALU_SLT;
          FUNCT_NOR: operador = ALU_NOR;
          default: begin
            operador = ALU_NOP;
            funct_ok = 1'b0;
          end
        endcase
      end
      default: operador = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand/immediate select, ALU decode, branch target; 1-cycle latency.
// Edge priority flush > stall > load; ILLEGAL_OP_EN enables trapping of unsupported R-type funct.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int SIZEDATA = 32,
  parameter int OP       = 4,
  parameter int REGADDR  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [SIZEDATA-1:0] pc4_in,
  input  logic [SIZEDATA-1:0] rs_dato,
  input  logic [SIZEDATA-1:0] rt_dato,
  input  logic [15:0]         inmediato,
  input  logic [REGADDR-1:0]  rt_dir,
  input  logic [REGADDR-1:0]  rd_dir,
  input  logic [1:0]          aluop,
  input  logic                alusrc,
  input  logic                regdst,
  input  logic                ext_cero,
  input  logic                regwrite_in,
  input  logic                memread_in,
  input  logic                memwrite_in,
  input  logic                memtoreg_in,
  input  logic                branch_in,
  output logic [SIZEDATA-1:0] a,
  output logic [SIZEDATA-1:0] b,
  output logic [OP-1:0]       operador,
  output logic [SIZEDATA-1:0] dato_store,
  output logic [REGADDR-1:0]  dest,
  output logic [SIZEDATA-1:0] target_salto,
  output logic                regwrite,
  output logic                memread,
  output logic                memwrite,
  output logic                memtoreg,
  output logic                branch,
  output logic                valid,
  output logic                ilegal
);

  logic [OPW-1:0]      op_dec;
  logic                funct_ok;
  logic [SIZEDATA-1:0] imm_sext;
  logic [SIZEDATA-1:0] imm_ext;
  logic [SIZEDATA-1:0] b_nxt;
  logic [SIZEDATA-1:0] target_nxt;
  logic                bad_funct;
  logic                kill_wr;

  alu_control u_alu_control (
    .aluop    (aluop),
    .funct    (inmediato[5:0]),
    .operador (op_dec),
    .funct_ok (funct_ok)
  );

  assign imm_sext   = {{(SIZEDATA-16){inmediato[15]}}, inmediato};
  assign imm_ext    = ext_cero ? {{(SIZEDATA-16){1'b0}}, inmediato} : imm_sext;
  assign b_nxt      = alusrc ? imm_ext : rt_dato;
  // Branch offsets are always signed, independent of ext_cero.
  assign target_nxt = pc4_in + (imm_sext << 2);
  assign bad_funct  = valid_in & (aluop_e'(aluop) == ALUOP_RTYPE) & ~funct_ok;

`ifdef ILLEGAL_OP_EN
  assign kill_wr = bad_funct;
`else
  logic unused_bad_funct;
  assign unused_bad_funct = bad_funct;
  assign kill_wr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a            <= '0;
      b            <= '0;
      operador     <= '0;
      dato_store   <= '0;
      dest         <= '0;
      target_salto <= '0;
      regwrite     <= 1'b0;
      memread      <= 1'b0;
      memwrite     <= 1'b0;
      memtoreg     <= 1'b0;
      branch       <= 1'b0;
      valid        <= 1'b0;
    end else if (flush) begin
      a            <= '0;
      b            <= '0;
      operador     <= '0;
      dato_store   <= '0;
      dest         <= '0;
      target_salto <= '0;
      regwrite     <= 1'b0;
      memread      <= 1'b0;
      memwrite     <= 1'b0;
      memtoreg     <= 1'b0;
      branch       <= 1'b0;
      valid        <= 1'b0;
    end else if (!stall) begin
      a            <= rs_dato;
      b            <= b_nxt;
      operador     <= OP'(op_dec);
      dato_store   <= rt_dato;
      dest         <= regdst ? rd_dir : rt_dir;
      target_salto <= target_nxt;
      // A bubble (valid_in low) still carries data, but never its side effects.
      regwrite     <= valid_in & regwrite_in & ~kill_wr;
      memread      <= valid_in & memread_in & ~kill_wr;
      memwrite     <= valid_in & memwrite_in & ~kill_wr;
      memtoreg     <= valid_in & memtoreg_in;
      branch       <= valid_in & branch_in;
      valid        <= valid_in;
    end
  end

`ifdef ILLEGAL_OP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ilegal <= 1'b0;
    end else if (flush) begin
      ilegal <= 1'b0;
    end else if (!stall) begin
      ilegal <= bad_funct;
    end
  end
`else
  assign ilegal = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations are hand-computed constants.
// Illegal-funct expectations follow whether ILLEGAL_OP_EN is defined for the build.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, valid_in;
  logic [31:0] pc4_in, rs_dato, rt_dato;
  logic [15:0] inmediato;
  logic [4:0]  rt_dir, rd_dir;
  logic [1:0]  aluop;
  logic        alusrc, regdst, ext_cero;
  logic        regwrite_in, memread_in, memwrite_in, memtoreg_in, branch_in;
  logic [31:0] a, b, dato_store, target_salto;
  logic [3:0]  operador;
  logic [4:0]  dest;
  logic        regwrite, memread, memwrite, memtoreg, branch, valid, ilegal;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .pc4_in(pc4_in), .rs_dato(rs_dato), .rt_dato(rt_dato), .inmediato(inmediato),
    .rt_dir(rt_dir), .rd_dir(rd_dir), .aluop(aluop), .alusrc(alusrc), .regdst(regdst),
    .ext_cero(ext_cero), .regwrite_in(regwrite_in), .memread_in(memread_in),
    .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in), .branch_in(branch_in),
    .a(a), .b(b), .operador(operador), .dato_store(dato_store), .dest(dest),
    .target_salto(target_salto), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .branch(branch), .valid(valid),
    .ilegal(ilegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [15:0] imm, input logic [31:0] rs,
                           input logic [31:0] rt, input logic src, input logic dst, input logic zx);
    valid_in  = 1'b1;
    aluop     = op;
    inmediato = imm;
    rs_dato   = rs;
    rt_dato   = rt;
    alusrc    = src;
    regdst    = dst;
    ext_cero  = zx;
  endtask

  logic [5:0] fn_tab [4];
  logic [3:0] op_tab [4];
  logic       exp_ilegal, exp_rw;

  initial begin
    fn_tab[0] = 6'b100100; op_tab[0] = 4'b0000;
    fn_tab[1] = 6'b101010; op_tab[1] = 4'b0111;
    fn_tab[2] = 6'b100111; op_tab[2] = 4'b1100;
    fn_tab[3] = 6'b100000; op_tab[3] = 4'b0010;
`ifdef ILLEGAL_OP_EN
    exp_ilegal = 1'b1; exp_rw = 1'b0;
`else
    exp_ilegal = 1'b0; exp_rw = 1'b1;
`endif

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    pc4_in = '0; rs_dato = '0; rt_dato = '0; inmediato = '0; rt_dir = '0; rd_dir = '0;
    aluop = 2'b00; alusrc = 1'b0; regdst = 1'b0; ext_cero = 1'b0;
    regwrite_in = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0; memtoreg_in = 1'b0; branch_in = 1'b0;
    #12;
    check("rst_a", a, 32'h0);
    check("rst_operador", {28'h0, operador}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    rst_n = 1'b1;

    // R-type sub
    set_instr(2'b10, 16'h0022, 32'd7, 32'd3, 1'b0, 1'b1, 1'b0);
    rt_dir = 5'd3; rd_dir = 5'd9; regwrite_in = 1'b1; pc4_in = 32'h40;
    tick();
    check("sub_a", a, 32'd7);
    check("sub_b", b, 32'd3);
    check("sub_operador", {28'h0, operador}, 32'h6);
    check("sub_dest", {27'h0, dest}, 32'd9);
    check("sub_valid", {31'h0, valid}, 32'h1);
    check("sub_regwrite", {31'h0, regwrite}, 32'h1);
    check("sub_ilegal", {31'h0, ilegal}, 32'h0);

    // lw with negative offset
    set_instr(2'b00, 16'hFFFC, 32'h1000, 32'h55, 1'b1, 1'b0, 1'b0);
    pc4_in = 32'h100; rt_dir = 5'd4; memread_in = 1'b1; memtoreg_in = 1'b1;
    tick();
    check("lw_b", b, 32'hFFFF_FFFC);
    check("lw_operador", {28'h0, operador}, 32'h2);
    check("lw_target", target_salto, 32'h0000_00F0);
    check("lw_dest", {27'h0, dest}, 32'd4);
    check("lw_memread", {31'h0, memread}, 32'h1);
    check("lw_dato_store", dato_store, 32'h55);

    // ori zero-extended; branch target still sign-extends
    set_instr(2'b11, 16'h8001, 32'h0F00, 32'h0, 1'b1, 1'b0, 1'b1);
    pc4_in = 32'h200; memread_in = 1'b0; memtoreg_in = 1'b0;
    tick();
    check("ori_b", b, 32'h0000_8001);
    check("ori_operador", {28'h0, operador}, 32'h1);
    check("ori_target", target_salto, 32'hFFFE_0204);

    // Stall two cycles with changing inputs
    stall = 1'b1;
    set_instr(2'b01, 16'h1234, 32'hAAAA, 32'hBBBB, 1'b0, 1'b1, 1'b0);
    tick();
    pc4_in = 32'h999; rd_dir = 5'd31; regwrite_in = 1'b0;
    tick();
    check("stall_b", b, 32'h0000_8001);
    check("stall_a", a, 32'h0F00);
    check("stall_operador", {28'h0, operador}, 32'h1);
    check("stall_regwrite", {31'h0, regwrite}, 32'h1);
    check("stall_valid", {31'h0, valid}, 32'h1);

    // Flush wins over stall
    flush = 1'b1;
    tick();
    check("flush_valid", {31'h0, valid}, 32'h0);
    check("flush_regwrite", {31'h0, regwrite}, 32'h0);
    check("flush_a", a, 32'h0);
    check("flush_target", target_salto, 32'h0);
    stall = 1'b0; flush = 1'b0;

    // Bubble load: data through, controls cleared
    set_instr(2'b00, 16'h0004, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0);
    valid_in = 1'b0; regwrite_in = 1'b1; memwrite_in = 1'b1; branch_in = 1'b1;
    tick();
    check("bubble_a", a, 32'h1234);
    check("bubble_regwrite", {31'h0, regwrite}, 32'h0);
    check("bubble_memwrite", {31'h0, memwrite}, 32'h0);
    check("bubble_branch", {31'h0, branch}, 32'h0);
    memwrite_in = 1'b0; branch_in = 1'b0;

    // Unsupported funct
    set_instr(2'b10, 16'h0000, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0);
    regwrite_in = 1'b1;
    tick();
    check("bad_operador", {28'h0, operador}, 32'hF);
    check("bad_ilegal", {31'h0, ilegal}, {31'h0, exp_ilegal});
    check("bad_regwrite", {31'h0, regwrite}, {31'h0, exp_rw});
    stall = 1'b1;
    tick();
    check("bad_hold_ilegal", {31'h0, ilegal}, {31'h0, exp_ilegal});
    stall = 1'b0;

    // Next legal load clears ilegal
    inmediato = 16'h0025;
    tick();
    check("or_operador", {28'h0, operador}, 32'h1);
    check("or_ilegal", {31'h0, ilegal}, 32'h0);
    check("or_regwrite", {31'h0, regwrite}, 32'h1);

    for (int i = 0; i < 4; i++) begin
      inmediato = {10'h0, fn_tab[i]};
      tick();
      check($sformatf("funct_%0d", i), {28'h0, operador}, {28'h0, op_tab[i]});
    end

    // Target wrap-around
    set_instr(2'b01, 16'h0002, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    pc4_in = 32'hFFFF_FFFC; branch_in = 1'b1;
    tick();
    check("wrap_target", target_salto, 32'h0000_0004);
    check("wrap_branch", {31'h0, branch}, 32'h1);
    check("wrap_operador", {28'h0, operador}, 32'h6);

    // Asynchronous reset mid-cycle under stall
    stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_target", target_salto, 32'h0);
    check("arst_branch", {31'h0, branch}, 32'h0);
    check("arst_operador", {28'h0, operador}, 32'h0);
    check("arst_valid", {31'h0, valid}, 32'h0);
    check("arst_dest", {27'h0, dest}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 32-bit MIPS datapath; sits directly upstream of the ALU and feeds its a, b and 4-bit operator inputs.
- Decodes the ALU operator from aluop/funct and selects operand B (register or extended immediate).
- Computes the branch target and registers all datapath and control signals for the EX stage.
- Supports pipeline stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- SIZEDATA, 32, datapath width.
- OP, 4, ALU operator width.
- REGADDR, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all registered outputs this edge
- flush  in  1  insert bubble this edge
- valid_in  in  1  ID holds a real instruction
- pc4_in  in  SIZEDATA  PC+4 of the instruction
- rs_dato  in  SIZEDATA  register-file read port 1
- rt_dato  in  SIZEDATA  register-file read port 2
- inmediato  in  16  instruction[15:0]
- rt_dir, rd_dir  in  REGADDR  instruction rt and rd fields
- aluop  in  2  from main control
- alusrc, regdst, ext_cero  in  1 each  select immediate / select rd / zero-extend immediate
- regwrite_in, memread_in, memwrite_in, memtoreg_in, branch_in  in  1 each  control bits
- a  out  SIZEDATA  ALU operand A
- b  out  SIZEDATA  ALU operand B
- operador  out  OP  ALU operator
- dato_store  out  SIZEDATA  rt_dato passthrough for stores
- dest  out  REGADDR  write-back register
- target_salto  out  SIZEDATA  branch target
- regwrite, memread, memwrite, memtoreg, branch, valid  out  1 each  registered control bits
- ilegal  out  1  unsupported R-type funct (see Optional Feature)

Behaviour:
- Reset: asynchronous on rst_n low. All outputs go to 0, including operador=4'b0000 and valid=0.
- Latency: 1 cycle. Inputs present at edge N appear on the outputs after edge N.
- Priority at each rising edge: flush > stall > load.
  - flush=1: valid, regwrite, memread, memwrite, memtoreg, branch and ilegal go to 0. Data outputs are cleared to 0 and operador goes to 4'b0000. This holds even when stall=1.
  - stall=1, flush=0: every output holds its value.
  - Otherwise: load from the inputs.
- On load, if valid_in=0, all control bits are loaded as 0 (bubble). Data is loaded normally.
- ALU control:
  - aluop=00: operador 0010 (add).
  - aluop=01: operador 0110 (sub).
  - aluop=11: operador 0001 (or, for ori).
  - aluop=10: decode funct=inmediato[5:0]: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100. Any other funct->1111 (the ALU yields 0).
- Immediate extension: ext_cero=1 zero-extends inmediato; otherwise it is sign-extended.
- b = alusrc ? extended immediate : rt_dato. a = rs_dato.
- dest = regdst ? rd_dir : rt_dir.
- target_salto = pc4_in + (sign-extended immediate << 2), modulo 2^SIZEDATA. Wrap-around is silent. It always uses sign extension, regardless of ext_cero.
- reset mid-stall: rst_n low wins immediately; stall and flush are ignored while rst_n is low.

Optional Feature:
- Macro ILLEGAL_OP_EN.
- Defined: on load with valid_in=1, aluop=10 and an unsupported funct, ilegal is registered as 1 and regwrite, memwrite and memread are forced to 0. ilegal is cleared by the next load, by flush or by reset. It holds under stall.
- Undefined: ilegal is tied to 0, and unsupported funct values propagate their control bits unchanged.

Decomposition:
- Package mips_pkg holds:
  - ALU operator localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_NOP=4'b1111.
  - aluop encodings.
  - funct codes.
- One combinational sub-module, alu_control (aluop, funct -> operador, funct_ok), instantiated inside id_ex_stage.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with outputs nonzero -> all outputs 0 immediately, without waiting for clk.
- R-type sub: aluop=10, funct=100010, rs=7, rt=3, alusrc=0, regdst=1, rd=9 -> after 1 edge a=7, b=3, operador=0110, dest=9, valid=1.
- lw with negative offset: aluop=00, alusrc=1, inmediato=16'hFFFC, ext_cero=0, pc4=0x100 -> b=0xFFFFFFFC, operador=0010, target_salto=0xF0.
- ori with zero-extension: aluop=11, ext_cero=1, inmediato=16'h8001 -> b=0x00008001, operador=0001.
- Stall then flush together: load an instruction, then stall=1 for 2 cycles with changing inputs -> outputs unchanged; then flush=1 with stall=1 -> valid=0 and all control bits 0.
- ILLEGAL_OP_EN on: aluop=10, funct=000000, regwrite_in=1 -> ilegal=1, regwrite=0, operador=1111. Same stimulus with the macro off -> ilegal=0, regwrite=1.
